// File: rtl/axi4_lite_bar_regs_if.sv
// AXI4-Lite bundle between the PCIe wrapper BAR port (master) and a register slave.
interface axi4_lite_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport s (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
           rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid,
           rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_bar_regs.sv
// AXI4-Lite register bank behind a PCIe BAR: reg 0 ID, reg 1 status, regs 2.. RW (reg 2 = ctrl).
// Define AXI_REGS_WSTRB_EN to honour write byte strobes; otherwise all 32 bits are written.
module axi4_lite_bar_regs #(
  parameter int unsigned N_REGS   = 16,
  parameter logic [31:0] ID_VALUE = 32'hFB00_0001
) (
  input  logic        bar_clk,
  input  logic        bar_rst,
  axi4_lite_if.s      bar,
  input  logic [31:0] status_i,
  output logic [31:0] ctrl_o,
  output logic        wr_stb_o,
  output logic [7:0]  wr_idx_o
);
  localparam int unsigned IW         = $clog2(N_REGS);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic          alive_q;
  logic          aw_full_q;
  logic [31:0]   aw_addr_q;
  logic          w_full_q;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [31:0]   status_q;
  logic          wr_stb_q;
  logic [7:0]    wr_idx_q;
  logic [31:0]   regs_q [N_REGS];

  logic          aw_hs, w_hs, ar_hs;
  logic          commit;
  logic [31:0]   wr_addr, wr_data, wr_mask;
  logic [3:0]    wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_ok, rd_oor;
  logic [31:0]   rd_val;

  // Ready lines stay low until the first edge after reset; AW/W also wait out a pending B.
  assign bar.awready = alive_q && !aw_full_q && !bvalid_q;
  assign bar.wready  = alive_q && !w_full_q && !bvalid_q;
  assign bar.arready = alive_q && (!rvalid_q || bar.rready);
  assign bar.bvalid  = bvalid_q;
  assign bar.bresp   = bresp_q;
  assign bar.rvalid  = rvalid_q;
  assign bar.rdata   = rdata_q;
  assign bar.rresp   = rresp_q;

  assign aw_hs = bar.awvalid && bar.awready;
  assign w_hs  = bar.wvalid && bar.wready;
  assign ar_hs = bar.arvalid && bar.arready;

  // A holder being filled this edge counts as full, so AW+W together commit immediately.
  assign wr_addr = aw_full_q ? aw_addr_q : bar.awaddr;
  assign wr_data = w_full_q ? w_data_q : bar.wdata;
  assign wr_strb = w_full_q ? w_strb_q : bar.wstrb;
  assign commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;
  assign wr_idx  = wr_addr[IW+1:2];
  assign wr_ok   = !(|wr_addr[31:IW+2]) && (wr_idx[IW-1:1] != '0);

  always_comb begin
    wr_mask = '1;
`ifdef AXI_REGS_WSTRB_EN
    for (int k = 0; k < 4; k++) begin
      wr_mask[8*k +: 8] = {8{wr_strb[k]}};
    end
`endif
  end

  assign rd_idx = bar.araddr[IW+1:2];
  assign rd_oor = |bar.araddr[31:IW+2];

  always_comb begin
    rd_val = regs_q[rd_idx];
    if (rd_oor) begin
      rd_val = 32'hDEAD_BEEF;
    end else if (rd_idx == '0) begin
      rd_val = ID_VALUE;
    end else if (int'(rd_idx) == 1) begin
      rd_val = status_q;
    end
  end

  always_ff @(posedge bar_clk or posedge bar_rst) begin
    if (bar_rst) begin
      alive_q   <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      alive_q  <= 1'b1;
      wr_stb_q <= commit && wr_ok;
      wr_idx_q <= (commit && wr_ok) ? 8'(wr_idx) : 8'd0;
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RespOkay : RespSlvErr;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_addr_q <= bar.awaddr;
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          w_data_q <= bar.wdata;
          w_strb_q <= bar.wstrb;
        end
        if (bar.bready) begin
          bvalid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge bar_clk or posedge bar_rst) begin
    if (bar_rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit && wr_ok) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (int'(wr_idx) == i) begin
          regs_q[i] <= (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
        end
      end
    end
  end

  // rd_val reads the pre-edge registers, so a same-cycle commit is not visible to this read.
  always_ff @(posedge bar_clk or posedge bar_rst) begin
    if (bar_rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
      status_q <= '0;
    end else begin
      status_q <= status_i;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_oor ? RespSlvErr : RespOkay;
      end else if (bar.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign ctrl_o   = regs_q[2];
  assign wr_stb_o = wr_stb_q;
  assign wr_idx_o = wr_idx_q;

  logic unused_ok;
  assign unused_ok = ^{bar.awprot, bar.arprot, wr_addr[1:0], bar.araddr[1:0], wr_strb};
endmodule
